// File: rtl/franken_dmem_ctrl.sv
// franken_dmem_ctrl: data-memory controller behind the franken_riscv MEM stage.
// Stores are posted into a small circular buffer and drained in program order
// ahead of any load. Loads stall the core (rbusy) until their bus read completes.
// Optional bus timeout: define FRANKEN_DMEM_TIMEOUT_EN.
module franken_dmem_ctrl #(
  parameter int unsigned WBUF_DEPTH  = 2,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_enable_MEM,
  input  logic        mem_write_enable_MEM,
  input  logic [31:0] alu_result_MEM,
  input  logic [31:0] write_data_MEM,
  input  logic [3:0]  byte_enable,
  output logic [31:0] read_data,
  output logic        rbusy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  // Pointers carry one extra wrap bit; full = same index, opposite wrap bit.
  localparam int unsigned PtrW = $clog2(WBUF_DEPTH) + 1;
  localparam int unsigned IdxW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrMsb = PtrW'(1) << (PtrW - 1);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StRdDone} state_e;

  state_e state_q, state_d;

  logic [29:0]     wb_addr_q [WBUF_DEPTH];
  logic [31:0]     wb_data_q [WBUF_DEPTH];
  logic [3:0]      wb_be_q   [WBUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            wb_empty, wb_full;
  logic            push, pop;
  logic            tmo_hit;

  logic [31:0] bus_addr_q, bus_wdata_q, read_data_q;
  logic [3:0]  bus_be_q;

  if (WBUF_DEPTH > 1) begin : g_idx
    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];
  end else begin : g_idx_single
    assign wr_idx = '0;
    assign rd_idx = '0;
  end

  assign wb_empty = (wr_ptr_q == rd_ptr_q);
  assign wb_full  = (wr_ptr_q == (rd_ptr_q ^ PtrMsb));

  // A simultaneous load wins over a store; a full buffer refuses the push even
  // if a pop lands in the same cycle.
  assign push = mem_write_enable_MEM && !mem_read_enable_MEM && !wb_full;
  assign pop  = (state_q == StWr) && (bus_ack || tmo_hit);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: drain writes first, then service a pending load
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!wb_empty) begin
          state_d = StWr;
        end else if (mem_read_enable_MEM) begin
          state_d = StRd;
        end
      end
      StWr:     if (bus_ack || tmo_hit) state_d = StIdle;
      StRd:     if (bus_ack || tmo_hit) state_d = StRdDone;
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register; rbusy is forced low in reset
  always_comb begin
    bus_req = (state_q == StWr) || (state_q == StRd);
    bus_we  = (state_q == StWr);
    rbusy   = 1'b0;
    if (reset) begin
      if (mem_read_enable_MEM) begin
        rbusy = (state_q != StRdDone);
      end else begin
        rbusy = mem_write_enable_MEM && wb_full;
      end
    end
  end

  // Buffer pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Buffer storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_idx] <= alu_result_MEM[31:2];
      wb_data_q[wr_idx] <= write_data_MEM;
      wb_be_q[wr_idx]   <= byte_enable;
    end
  end

  // Bus fields latched when leaving IDLE and held for the whole transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else if (state_q == StIdle) begin
      if (!wb_empty) begin
        bus_addr_q  <= {wb_addr_q[rd_idx], 2'b00};
        bus_wdata_q <= wb_data_q[rd_idx];
        bus_be_q    <= wb_be_q[rd_idx];
      end else if (mem_read_enable_MEM) begin
        bus_addr_q  <= {alu_result_MEM[31:2], 2'b00};
        bus_be_q    <= byte_enable;
      end
    end
  end

  // Load result register; holds until the next read completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q <= '0;
    end else if (state_q == StRd) begin
      if (bus_ack) begin
        read_data_q <= bus_rdata;
      end else if (tmo_hit) begin
        read_data_q <= ERR_RDATA;
      end
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign read_data = read_data_q;

`ifdef FRANKEN_DMEM_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CntW-1:0] tmo_cnt_q;
  logic            bus_err_q;

  // The counter sits at zero outside WR/RD, so each transaction starts fresh
  assign tmo_hit = bus_req && !bus_ack && (tmo_cnt_q == CntW'(TIMEOUT_CYC - 1));

  // Timeout counter and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (!bus_req) begin
        tmo_cnt_q <= '0;
      end else if (!bus_ack) begin
        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
      end
      if (tmo_hit) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // Byte offset is irrelevant on a word-wide bus
  logic unused_addr_lo;
  assign unused_addr_lo = ^alu_result_MEM[1:0];

endmodule

// File: tb/tb_franken_dmem_ctrl.sv
// tb_franken_dmem_ctrl: directed bench for franken_dmem_ctrl with a queue-based
// reference model checked every cycle, plus literal expectations per scenario.
module tb_franken_dmem_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TMO   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] read_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        rbusy, bus_req, bus_we, bus_err;

  franken_dmem_ctrl #(
    .WBUF_DEPTH (DEPTH),
    .TIMEOUT_CYC(TMO),
    .ERR_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_read_enable_MEM (rd_en),
    .mem_write_enable_MEM(wr_en),
    .alu_result_MEM      (addr),
    .write_data_MEM      (wdata),
    .byte_enable         (be),
    .read_data           (read_data),
    .rbusy               (rbusy),
    .bus_req             (bus_req),
    .bus_we              (bus_we),
    .bus_addr            (bus_addr),
    .bus_wdata           (bus_wdata),
    .bus_be              (bus_be),
    .bus_ack             (bus_ack),
    .bus_rdata           (bus_rdata),
    .bus_err             (bus_err)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no response, expected one", name);
  endtask

  // ---------------- bus responder: ack on the ack_delay-th req cycle ----------
  int          ack_delay = 1;  // 0 = never ack
  logic [31:0] rd_value  = '0;
  int          req_cnt   = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (bus_req) req_cnt++;
    else         req_cnt = 0;
    bus_ack   = bus_req && (ack_delay != 0) && (req_cnt == ack_delay);
    bus_rdata = bus_ack ? rd_value : 32'h0;
  end

  // ---------------- transaction log -------------------------------------------
  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } xact_t;
  xact_t xlog[$];

  initial forever begin
    @(negedge clk);
    if (reset && bus_req && bus_ack)
      xlog.push_back('{we: bus_we, a: bus_addr, d: (bus_we ? bus_wdata : bus_rdata), b: bus_be});
  end

  // ---------------- reference model -------------------------------------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;
  wr_t         wq[$];       // posted writes, oldest first
  int          m_active;    // 0 none, 1 bus write in flight, 2 bus read in flight
  bit          m_done;      // the single cycle in which a finished load is released
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  bit          m_err;
  int          m_cnt;       // cycles spent waiting in the current transaction

  task automatic model_step();
    bit full_pre = (wq.size() == DEPTH);
    bit tmo = 1'b0;
`ifdef FRANKEN_DMEM_TIMEOUT_EN
    tmo = (m_active != 0) && !bus_ack && (m_cnt == TMO - 1);
`endif
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_active != 0) begin
      if (bus_ack || tmo) begin
        if (m_active == 1) begin
          void'(wq.pop_front());
        end else begin
          m_rdata = bus_ack ? bus_rdata : 32'hDEADBEEF;
          m_done  = 1'b1;
        end
        m_active = 0;
        if (tmo) m_err = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (wq.size() != 0) begin
      m_active = 1;
      m_cnt    = 0;
    end else if (rd_en) begin
      m_active = 2;
      m_addr   = {addr[31:2], 2'b00};
      m_be     = be;
      m_cnt    = 0;
    end
    if (wr_en && !rd_en && !full_pre)
      wq.push_back('{a: {addr[31:2], 2'b00}, d: wdata, b: be});
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      wq.delete();
      m_active = 0;
      m_done   = 1'b0;
      m_rdata  = '0;
      m_err    = 1'b0;
      m_cnt    = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare -----------------------------------------
  initial forever begin
    logic exp_rbusy;
    @(negedge clk);
    if (rd_en) exp_rbusy = reset && !m_done;
    else       exp_rbusy = reset && wr_en && (wq.size() == DEPTH);
    chk("rbusy", 32'(rbusy), 32'(exp_rbusy));
    chk("bus_req", 32'(bus_req), 32'(m_active != 0));
    chk("read_data", read_data, m_rdata);
    chk("bus_err", 32'(bus_err), 32'(m_err));
    if (!reset) begin
      chk("rst_bus_we", 32'(bus_we), 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_bus_be", 32'(bus_be), 32'h0);
    end else if (bus_req && m_active != 0) begin
      chk("bus_we", 32'(bus_we), 32'(m_active == 1));
      if (m_active == 1) begin
        chk("bus_addr_wr", bus_addr, wq[0].a);
        chk("bus_wdata", bus_wdata, wq[0].d);
        chk("bus_be_wr", 32'(bus_be), 32'(wq[0].b));
      end else begin
        chk("bus_addr_rd", bus_addr, m_addr);
        chk("bus_be_rd", 32'(bus_be), 32'(m_be));
      end
    end
  end

  // ---------------- core-side drivers (called at posedge+1) -------------------
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                          output int stalls);
    bit ok = 1'b0;
    rd_en = 1'b0; wr_en = 1'b1; addr = a; wdata = d; be = b;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rbusy) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) bound_fail("store_wait");
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] b,
                         output logic [31:0] rdv, output int stalls);
    bit ok = 1'b0;
    wr_en = 1'b0; rd_en = 1'b1; addr = a; be = b;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rbusy) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) bound_fail("load_wait");
    rdv = read_data;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic wait_log(input string name, input int n);
    for (int i = 0; i < 100; i++) begin
      if (xlog.size() >= n) break;
      @(negedge clk);
    end
    chk(name, 32'(xlog.size()), 32'(n));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------------------------------
  initial begin
    int          st;
    logic [31:0] rv;

    // Reset: a load request must not stall while reset is low
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rbusy", 32'(rbusy), 32'h0);
    chk("reset_bus_req", 32'(bus_req), 32'h0);
    chk("reset_read_data", read_data, 32'h0);
    rd_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(2);

    // 1: single store, ack in first req cycle
    xlog.delete();
    ack_delay = 1;
    do_store(32'h1000_0004, 32'hA5A5_0000, 4'b1100, st);
    chk("t1_stalls", 32'(st), 32'd0);
    wait_log("t1_count", 1);
    chk("t1_we", 32'(xlog[0].we), 32'h1);
    chk("t1_addr", xlog[0].a, 32'h1000_0004);
    chk("t1_data", xlog[0].d, 32'hA5A5_0000);
    chk("t1_be", 32'(xlog[0].b), 32'hC);
    idle_cycles(3);
    chk("t1_drained", 32'(bus_req), 32'h0);
    chk("t1_no_extra", 32'(xlog.size()), 32'd1);

    // 2: three back-to-back stores into a two-entry buffer, slow bus
    xlog.delete();
    ack_delay = 5;
    do_store(32'h0000_0200, 32'h0000_0001, 4'hF, st);
    chk("t2_stall0", 32'(st), 32'd0);
    do_store(32'h0000_0204, 32'h0000_0002, 4'hF, st);
    chk("t2_stall1", 32'(st), 32'd0);
    do_store(32'h0000_0208, 32'h0000_0003, 4'hF, st);
    chk("t2_stall2", 32'(st), 32'd5);
    wait_log("t2_count", 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_order_addr", xlog[i].a, 32'h200 + 32'(4 * i));
      chk("t2_order_data", xlog[i].d, 32'(i + 1));
    end
    idle_cycles(2);

    // 3: store then load to the same word; write must reach the bus first
    xlog.delete();
    ack_delay = 2;
    rd_value  = 32'h1234_5678;
    do_store(32'h0000_0100, 32'hCAFE_F00D, 4'hF, st);
    do_load(32'h0000_0100, 4'hF, rv, st);
    chk("t3_rdata", rv, 32'h1234_5678);
    chk("t3_stalls", 32'(st), 32'd6);
    wait_log("t3_count", 2);
    chk("t3_first_is_wr", 32'(xlog[0].we), 32'h1);
    chk("t3_second_is_rd", 32'(xlog[1].we), 32'h0);
    chk("t3_rd_addr", xlog[1].a, 32'h0000_0100);
    idle_cycles(2);

    // 4: two consecutive loads with the read enable held high
    xlog.delete();
    ack_delay = 1;
    rd_value  = 32'h1111_0000;
    do_load(32'h0000_0300, 4'hF, rv, st);
    chk("t4_rdata0", rv, 32'h1111_0000);
    chk("t4_stalls0", 32'(st), 32'd2);
    rd_value = 32'h2222_0000;
    do_load(32'h0000_0306, 4'b0011, rv, st);
    chk("t4_rdata1", rv, 32'h2222_0000);
    chk("t4_stalls1", 32'(st), 32'd2);
    wait_log("t4_count", 2);
    chk("t4_addr1", xlog[1].a, 32'h0000_0304);
    chk("t4_be1", 32'(xlog[1].b), 32'h3);
    idle_cycles(2);

    // 5: reset asserted while a read is outstanding
    xlog.delete();
    ack_delay = 0;
    rd_en = 1'b1; addr = 32'h0000_0400; be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_req) break;
    end
    chk("t5_req_seen", 32'(bus_req), 32'h1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t5_req_async", 32'(bus_req), 32'h0);
    chk("t5_rbusy", 32'(rbusy), 32'h0);
    rd_en = 1'b0;
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(4);
    chk("t5_idle_req", 32'(bus_req), 32'h0);
    chk("t5_no_xact", 32'(xlog.size()), 32'd0);

`ifdef FRANKEN_DMEM_TIMEOUT_EN
    // 6: load that never gets an ack times out after TMO req cycles
    do_load(32'h0000_0600, 4'hF, rv, st);
    chk("t6_rdata", rv, 32'hDEADBEEF);
    chk("t6_stalls", 32'(st), 32'd9);
    idle_cycles(5);
    chk("t6_err_sticky", 32'(bus_err), 32'h1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t6_err_cleared", 32'(bus_err), 32'h0);
    idle_cycles(1);
    reset = 1'b1;
    idle_cycles(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/franken_dmem_ctrl.md
Name: franken_dmem_ctrl

Overview:
- Data-memory controller directly downstream of the franken_riscv MEM stage.
- Consumes the core's memory controls: mem_read_enable_MEM, mem_write_enable_MEM, alu_result_MEM, write_data_MEM, byte_enable.
- Returns read_data and the rbusy stall to the core.
- Drives a single-master req/ack data bus, with a small posted-write buffer so that stores do not stall the pipeline.

Parameters:
- WBUF_DEPTH, 2, posted-write buffer entries (power of two, ≥1).
- TIMEOUT_CYC, 255, cycles without bus_ack before a transaction is abandoned (only with the optional feature).
- ERR_RDATA, 32'hDEADBEEF, read_data value returned for a timed-out read.

Ports:
- clk  in  1  core clock; all logic is posedge.
- reset  in  1  asynchronous, active-low reset.
- mem_read_enable_MEM  in  1  load request from the core.
- mem_write_enable_MEM  in  1  store request from the core.
- alu_result_MEM  in  32  byte address of the request.
- write_data_MEM  in  32  lane-aligned store data.
- byte_enable  in  4  lane enables for the request.
- read_data  out  32  raw 32-bit load word; the core performs lane extraction.
- rbusy  out  1  stall to the core; combinational.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  32  word address, {alu_result_MEM[31:2],2'b00}.
- bus_wdata  out  32  write data.
- bus_be  out  4  lane enables.
- bus_ack  in  1  transaction complete; meaningful only while bus_req=1.
- bus_rdata  in  32  read data, valid with bus_ack on a read.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE and the write buffer empties.
  - bus_req, bus_we, bus_addr, bus_wdata, bus_be, read_data and bus_err are all 0.
  - rbusy is forced to 0 while reset=0, so the core can load its reset PC.
  - Reset mid-transaction abandons the transaction immediately; bus_req falls asynchronously.
- Write path:
  - When mem_write_enable_MEM=1 and the buffer is not full, {addr, data, be} is pushed at posedge. No stall.
  - When the buffer is full, rbusy=1. No push happens, even if a pop occurs in the same cycle. The push happens on the first posedge after the buffer becomes not full.
- Read path:
  - rbusy = mem_read_enable_MEM && state!=RD_DONE.
  - Each load produces exactly one bus read.
- FSM, one state register:
  - IDLE:
    - If the buffer is not empty, go to WR. Writes drain before any read, giving strict program order.
    - Else if mem_read_enable_MEM=1, go to RD, latching address and byte_enable.
    - Else stay in IDLE.
  - WR: bus_req=1, bus_we=1, head entry driven. On bus_ack, pop the head and go to IDLE.
  - RD: bus_req=1, bus_we=0. On bus_ack, register bus_rdata into read_data and go to RD_DONE.
  - RD_DONE: lasts exactly one cycle with rbusy=0, so the core advances, then go to IDLE. A back-to-back load still holding mem_read_enable_MEM=1 starts a fresh read from IDLE.
- Bus rules:
  - bus_addr, bus_wdata, bus_be and bus_we are registered and held stable while bus_req=1.
  - bus_req deasserts in the cycle after the ack.
  - Ack in the first req cycle is legal, giving a minimum of 2 cycles per transaction including IDLE.
- Buffer:
  - Circular, with log2(WBUF_DEPTH)+1-bit pointers; full/empty are decided by the MSB compare; pointers wrap.
  - Simultaneous push and pop when not full: the count is unchanged.
- read_data holds its last value until the next read completes.
- If load and store requests are asserted together, that is a protocol violation; the load takes precedence.

Optional Feature:
- Macro: FRANKEN_DMEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entering WR/RD and increments each cycle without ack.
  - At TIMEOUT_CYC the FSM abandons the transaction:
    - WR: pop the head.
    - RD: read_data = ERR_RDATA, go to RD_DONE.
  - bus_err sets and stays 1 until reset.
- Undefined: no counter; WR/RD wait for bus_ack indefinitely; bus_err is tied 0.

Test Plan:
- Single store, addr 0x1000_0004, data 0xA5A5_0000, be 4'b1100, bus acks after 1 cycle → rbusy stays 0; one bus write with bus_addr 0x1000_0004, be 4'b1100; buffer empty 3 cycles later.
- Three back-to-back stores, WBUF_DEPTH=2, bus ack delayed 5 cycles → rbusy=1 on the third store until the first pop; all three writes appear in order.
- Store to 0x100 then load from 0x100, with bus ack 2 cycles → write completes before the read's bus_req; read_data = bus_rdata 0x1234_5678; rbusy=0 for exactly one cycle.
- Two consecutive loads, mem_read_enable_MEM held high → two distinct bus reads; rbusy drops once per load.
- reset pulled low while in RD with bus_req=1 → bus_req=0 immediately, rbusy=0, buffer empty, FSM in IDLE after release.
- With FRANKEN_DMEM_TIMEOUT_EN, TIMEOUT_CYC=8, load with no ack → after 8 cycles read_data=0xDEADBEEF, rbusy drops, bus_err=1 until reset.
